br_multipuerto: RTL and testbench

BR_MULTIPUERTO -- requirements
Module: br_multipuerto

---
 rtl/br_pkg.sv | 13 +
 rtl/br_mem.sv | 35 +++
 rtl/br_multipuerto.sv | 101 ++++++++++
 tb/tb_br_multipuerto.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/br_pkg.sv
// rtl/br_pkg.sv - default sizes and FSM state type shared by the multiport register bank
package br_pkg;

    localparam int BR_WIDTH = 32;
    localparam int BR_DEPTH = 32;
    localparam int BR_NRD   = 2;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } br_state_t;

endpackage

// File: rtl/br_mem.sv
// rtl/br_mem.sv - storage array, one synchronous write port and NRD asynchronous read ports
// clk : write clock
// we, wa, wd : write enable, address, data
// ra : packed read addresses, port k at [k*AW +: AW]
// rd : packed read data, port k at [k*WIDTH +: WIDTH]
module br_mem
    import br_pkg::*;
#(
    parameter  int WIDTH = BR_WIDTH,
    parameter  int DEPTH = BR_DEPTH,
    parameter  int NRD   = BR_NRD,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        wa,
    input  logic [WIDTH-1:0]     wd,
    input  logic [NRD*AW-1:0]    ra,
    output logic [NRD*WIDTH-1:0] rd
);

    // No reset on the array so it maps onto RAM; the owner zeroes it by writing.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        assign rd[k*WIDTH +: WIDTH] = mem[ra[k*AW +: AW]];
    end

endmodule

// File: rtl/br_multipuerto.sv
// rtl/br_multipuerto.sv - multiport register bank with post-reset clear, write-first bypass, optional BR_ZERO_REG_EN
// clk, rst : clock, synchronous active-high reset
// RegEn, Dir, Di : write enable, address, data
// RA : packed read addresses, port k at [k*AW +: AW]
// DR : packed registered read data, port k at [k*WIDTH +: WIDTH]
// busy : high while the clear sequence runs
module br_multipuerto
    import br_pkg::*;
#(
    parameter  int WIDTH = BR_WIDTH,
    parameter  int DEPTH = BR_DEPTH,
    parameter  int NRD   = BR_NRD,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RegEn,
    input  logic [AW-1:0]        Dir,
    input  logic [WIDTH-1:0]     Di,
    input  logic [NRD*AW-1:0]    RA,
    output logic [NRD*WIDTH-1:0] DR,
    output logic                 busy
);

    br_state_t            state;
    logic [AW-1:0]        clr_cnt;

    logic                 wr_ok;
    logic                 mem_we;
    logic [AW-1:0]        mem_wa;
    logic [WIDTH-1:0]     mem_wd;
    logic [NRD*WIDTH-1:0] mem_rd;
    logic [NRD*WIDTH-1:0] dr_next;

    // User write is accepted only in READY and never on a reset edge.
    always_comb begin
        wr_ok = RegEn && (state == READY) && !rst;
`ifdef BR_ZERO_REG_EN
        if (Dir == '0) begin
            wr_ok = 1'b0;
        end
`endif
        mem_we = wr_ok || ((state == CLEAR) && !rst);
        mem_wa = (state == CLEAR) ? clr_cnt : Dir;
        mem_wd = (state == CLEAR) ? '0 : Di;
    end

    br_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .NRD   (NRD)
    ) u_mem (
        .clk (clk),
        .we  (mem_we),
        .wa  (mem_wa),
        .wd  (mem_wd),
        .ra  (RA),
        .rd  (mem_rd)
    );

    // Write-first: a port reading the address being written sees the new data.
    always_comb begin
        dr_next = '0;
        for (int k = 0; k < NRD; k++) begin
            if (wr_ok && (RA[k*AW +: AW] == Dir)) begin
                dr_next[k*WIDTH +: WIDTH] = Di;
            end else begin
                dr_next[k*WIDTH +: WIDTH] = mem_rd[k*WIDTH +: WIDTH];
            end
`ifdef BR_ZERO_REG_EN
            if (RA[k*AW +: AW] == '0) begin
                dr_next[k*WIDTH +: WIDTH] = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
            DR      <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == AW'(DEPTH - 1)) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end
                end
                READY: begin
                    busy <= 1'b0;
                end
            endcase
            DR <= (state == CLEAR) ? '0 : dr_next;
        end
    end

endmodule

// File: tb/tb_br_multipuerto.sv
// tb/tb_br_multipuerto.sv - self-checking bench for br_multipuerto
module tb_br_multipuerto;

    localparam int W   = 32;
    localparam int D   = 32;
    localparam int N   = 2;
    localparam int AW  = 5;
    localparam int RAW = N * AW;

`ifdef BR_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           RegEn;
    logic [AW-1:0]  Dir;
    logic [W-1:0]   Di;
    logic [RAW-1:0] RA;
    logic [N*W-1:0] DR;
    logic           busy;

    logic           rst_s;
    logic           en_s;
    logic [2:0]     dir_s;
    logic [15:0]    di_s;
    logic [8:0]     ra_s;
    logic [47:0]    dr_s;
    logic           busy_s;

    br_multipuerto dut (
        .clk   (clk),
        .rst   (rst),
        .RegEn (RegEn),
        .Dir   (Dir),
        .Di    (Di),
        .RA    (RA),
        .DR    (DR),
        .busy  (busy)
    );

    br_multipuerto #(.WIDTH(16), .DEPTH(8), .NRD(3)) dut_small (
        .clk   (clk),
        .rst   (rst_s),
        .RegEn (en_s),
        .Dir   (dir_s),
        .Di    (di_s),
        .RA    (ra_s),
        .DR    (dr_s),
        .busy  (busy_s)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mem_m  [D];
    logic [W-1:0] exp_dr [N];

    // One READY cycle: drive, predict each port from the model, then update the model.
    task automatic step(input logic en, input logic [AW-1:0] dir, input logic [W-1:0] di,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        logic [AW-1:0] ra [N];
        ra[0] = a0;
        ra[1] = a1;
        @(negedge clk);
        RegEn = en; Dir = dir; Di = di; RA = {a1, a0};
        for (int k = 0; k < N; k++) begin
            if (ZERO_REG && ra[k] == 0)         exp_dr[k] = '0;
            else if (en && ra[k] == dir)        exp_dr[k] = di;
            else                                exp_dr[k] = mem_m[ra[k]];
        end
        if (en && !(ZERO_REG && dir == 0)) mem_m[dir] = di;
        @(posedge clk); #1;
    endtask

    // Release reset and run out the clear with writes offered every cycle.
    task automatic do_clear(input logic [AW-1:0] wdir, output int n, output int nz);
        n = 0; nz = 0;
        @(negedge clk);
        rst = 1'b0;
        while (busy === 1'b1 && n < 100) begin
            RegEn = 1'b1; Dir = wdir; Di = $urandom; RA = RAW'($urandom);
            @(posedge clk); #1;
            n++;
            if (DR !== '0) nz++;
            @(negedge clk);
        end
        RegEn = 1'b0;
        for (int i = 0; i < D; i++) mem_m[i] = '0;
    endtask

    task automatic test_reset;
        int n, nz;
        @(negedge clk);
        rst = 1'b1; RegEn = 1'b1; Dir = AW'($urandom); Di = $urandom;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %0b want 1", busy); end
        checks++;
        if (DR !== '0) begin errors++; $display("FAIL reset_dr got %h want 0", DR); end
        do_clear(AW'($urandom), n, nz);
        checks++;
        if (n != 32) begin errors++; $display("FAIL clear_len got %0d want 32", n); end
        checks++;
        if (nz != 0) begin errors++; $display("FAIL clear_dr_zero got %0d nonzero cycles want 0", nz); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL clear_done got %0b want 0", busy); end
    endtask

    task automatic test_read_all;
        for (int a = 0; a < D; a++) begin
            step(1'b0, '0, '0, AW'(a), AW'(D - 1 - a));
            for (int k = 0; k < N; k++) begin
                checks++;
                if (DR[k*W +: W] !== 32'h0) begin
                    errors++;
                    $display("FAIL read_all port%0d addr%0d got %h want 0", k, a, DR[k*W +: W]);
                end
            end
        end
    endtask

    task automatic test_write_read;
        step(1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2);
        step(1'b0, 5'd0, 32'h0, 5'd5, 5'd1);
        checks++;
        if (DR[W-1:0] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL write_read got %h want deadbeef", DR[W-1:0]);
        end
    endtask

    task automatic test_bypass;
        step(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7);
        checks++;
        if (DR[W-1:0] !== 32'h12345678) begin
            errors++; $display("FAIL bypass_p0 got %h want 12345678", DR[W-1:0]);
        end
        checks++;
        if (DR[2*W-1:W] !== 32'h12345678) begin
            errors++; $display("FAIL bypass_p1 got %h want 12345678", DR[2*W-1:W]);
        end
    endtask

    task automatic test_back_to_back;
        step(1'b1, 5'd9, 32'hAAAA0001, 5'd0, 5'd1);
        step(1'b1, 5'd9, 32'hBBBB0002, 5'd2, 5'd3);
        step(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        checks++;
        if (DR !== {32'hBBBB0002, 32'hBBBB0002}) begin
            errors++; $display("FAIL back_to_back got %h want bbbb0002 on both ports", DR);
        end
    endtask

    task automatic test_zero_reg;
        logic [W-1:0] zexp;
        zexp = ZERO_REG ? 32'h0 : 32'hFFFFFFFF;
        step(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        checks++;
        if (DR !== {zexp, zexp}) begin
            errors++; $display("FAIL zero_bypass got %h want %h on both ports", DR, zexp);
        end
        step(1'b0, 5'd0, 32'h0, 5'd0, 5'd1);
        checks++;
        if (DR[W-1:0] !== zexp) begin
            errors++; $display("FAIL zero_read got %h want %h", DR[W-1:0], zexp);
        end
    endtask

    task automatic test_random;
        logic [AW-1:0] dir, a0, a1;
        logic          en;
        for (int i = 0; i < 400; i++) begin
            en  = 1'($urandom);
            dir = AW'($urandom);
            a0  = ($urandom_range(0, 3) == 0) ? dir : AW'($urandom);
            a1  = ($urandom_range(0, 2) == 0) ? a0  : AW'($urandom);
            step(en, dir, $urandom, a0, a1);
            for (int k = 0; k < N; k++) begin
                checks++;
                if (DR[k*W +: W] !== exp_dr[k]) begin
                    errors++;
                    $display("FAIL random cyc%0d port%0d got %h want %h", i, k, DR[k*W +: W], exp_dr[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_clear;
        int n, nz;
        step(1'b1, 5'd3, 32'hA5A5A5A5, 5'd0, 5'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; RegEn = 1'b1; Dir = 5'd3; Di = 32'hFFFF0000;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midclr_busy got %0b want 1", busy); end
        do_clear(5'd3, n, nz);
        checks++;
        if (n != 32) begin errors++; $display("FAIL midclr_len got %0d want 32", n); end
        checks++;
        if (nz != 0) begin errors++; $display("FAIL midclr_dr_zero got %0d nonzero cycles want 0", nz); end
        step(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        checks++;
        if (DR !== '0) begin errors++; $display("FAIL midclr_addr3 got %h want 0", DR); end
    endtask

    task automatic test_small;
        int n;
        @(negedge clk);
        rst_s = 1'b1; en_s = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_s = 1'b0;
        n = 0;
        while (busy_s === 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != 8) begin errors++; $display("FAIL small_clear_len got %0d want 8", n); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            en_s = 1'b1; dir_s = 3'(k); di_s = 16'(k * 257);
            @(posedge clk);
        end
        @(negedge clk);
        en_s = 1'b0; ra_s = {3'd3, 3'd0, 3'd7};
        @(posedge clk); #1;
        checks++;
        if (dr_s[15:0] !== 16'h0707) begin errors++; $display("FAIL small_p0 got %h want 0707", dr_s[15:0]); end
        checks++;
        if (dr_s[31:16] !== 16'h0000) begin errors++; $display("FAIL small_p1 got %h want 0000", dr_s[31:16]); end
        checks++;
        if (dr_s[47:32] !== 16'h0303) begin errors++; $display("FAIL small_p2 got %h want 0303", dr_s[47:32]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; RegEn = 1'b0; Dir = '0; Di = '0; RA = '0;
        rst_s = 1'b1; en_s = 1'b0; dir_s = '0; di_s = '0; ra_s = '0;
        for (int i = 0; i < D; i++) mem_m[i] = '0;
        repeat (2) @(posedge clk);
        test_reset;
        test_read_all;
        test_write_read;
        test_bypass;
        test_back_to_back;
        test_zero_reg;
        test_random;
        test_reset_mid_clear;
        test_random;
        test_small;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
